// File: rtl/two_digit_countdown_pkg.sv
// Shared definitions for the two-digit BCD countdown timer: FSM states,
// digit limits, 7-segment glyphs and the small helpers built on them.
package two_digit_countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX   = 4'd9;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        logic [3:0] r;
        if (d > BCD_MAX) begin
            r = BCD_MAX;
        end else begin
            r = d;
        end
        return r;
    endfunction

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/two_digit_countdown_digit_down.sv
// One BCD digit decrementer: 0 wraps to 9 and raises borrow for the next digit.
module bcd_digit_down
    import two_digit_countdown_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dec,
    output logic [3:0] next,
    output logic       borrow
);

    // Decrement with wrap-to-nine when requested, otherwise pass through
    always_comb begin
        next   = digit;
        borrow = 1'b0;
        if (dec) begin
            if (digit == 4'd0) begin
                next   = BCD_MAX;
                borrow = 1'b1;
            end else begin
                next   = digit - 4'd1;
                borrow = 1'b0;
            end
        end else begin
            next   = digit;
            borrow = 1'b0;
        end
    end

endmodule

// File: rtl/two_digit_countdown.sv
// Two-digit BCD countdown timer: loadable preset, run/pause on a button edge,
// stops at 00 with done held; drives raw BCD and 7-segment digits.
module two_digit_countdown
    import two_digit_countdown_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] preset_1,
    input  logic [3:0] preset_10,
    input  logic       toggle,
    output logic [3:0] bcd_1,
    output logic [3:0] bcd_10,
    output logic [6:0] seg_1,
    output logic [6:0] seg_10,
    output logic       done
);

    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_ones;
    logic [3:0]    r_tens;
    logic [3:0]    w_ones_nxt;
    logic [3:0]    w_tens_nxt;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic          r_toggle_q;
    logic          r_done;
    logic          w_done_nxt;
    logic          w_rise;
    logic          w_tick;
    logic          w_is_zero;
    logic          w_is_one;
    logic [3:0]    w_ones_dec;
    logic [3:0]    w_tens_dec;
    logic          w_ones_borrow;
    logic          w_tens_borrow;

    assign w_rise    = toggle & ~r_toggle_q;
    assign w_is_zero = (r_tens == 4'd0) && (r_ones == 4'd0);
    assign w_is_one  = (r_tens == 4'd0) && (r_ones == 4'd1);
    // A tick only counts when nothing of higher priority claims the edge
    assign w_tick    = (r_state == ST_RUN) && (r_presc == PRESC_LAST) && !load && !w_rise;

    bcd_digit_down u_ones (
        .digit  (r_ones),
        .dec    (w_tick),
        .next   (w_ones_dec),
        .borrow (w_ones_borrow)
    );

    bcd_digit_down u_tens (
        .digit  (r_tens),
        .dec    (w_ones_borrow),
        .next   (w_tens_dec),
        .borrow (w_tens_borrow)
    );

    // Next-state, next-count and prescaler logic; priority load > rise > tick
    always_comb begin
        w_state_nxt = r_state;
        w_ones_nxt  = r_ones;
        w_tens_nxt  = r_tens;
        w_presc_nxt = r_presc;
        w_done_nxt  = 1'b0;
        if (load) begin
            w_state_nxt = ST_IDLE;
            w_ones_nxt  = bcd_clamp(preset_1);
            w_tens_nxt  = bcd_clamp(preset_10);
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise && !w_is_zero) begin
                        w_state_nxt = ST_RUN;
                        w_presc_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (w_rise) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (w_tick) begin
                        w_presc_nxt = '0;
                        // Tens borrow would mean decrementing 00: pin at zero instead
                        if (w_tens_borrow) begin
                            w_ones_nxt  = 4'd0;
                            w_tens_nxt  = 4'd0;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_ones_nxt  = w_ones_dec;
                            w_tens_nxt  = w_tens_dec;
                            w_state_nxt = w_is_one ? ST_DONE : ST_RUN;
                        end
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (w_rise) begin
                        w_state_nxt = ST_RUN;
                        w_presc_nxt = '0;
                    end else begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                    w_ones_nxt  = 4'd0;
                    w_tens_nxt  = 4'd0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_ones_nxt  = 4'd0;
                    w_tens_nxt  = 4'd0;
                    w_presc_nxt = '0;
                end
            endcase
        end
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // State, count, prescaler and edge-detect registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ones     <= 4'd0;
            r_tens     <= 4'd0;
            r_presc    <= '0;
            r_done     <= 1'b0;
            r_toggle_q <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_ones     <= w_ones_nxt;
            r_tens     <= w_tens_nxt;
            r_presc    <= w_presc_nxt;
            r_done     <= w_done_nxt;
            r_toggle_q <= toggle;
        end
    end

    assign bcd_1  = r_ones;
    assign bcd_10 = r_tens;
    assign seg_1  = bcd_to_seg(r_ones);
    assign seg_10 = bcd_to_seg(r_tens);
    assign done   = r_done;

endmodule

// File: tb/tb_two_digit_countdown.sv
// Directed and randomized bench for two_digit_countdown against an
// integer-count reference model that advances once per clock edge.
module tb_two_digit_countdown;

    localparam int TD = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       toggle = 1'b0;
    logic [3:0] preset_1 = 4'd0;
    logic [3:0] preset_10 = 4'd0;
    logic [3:0] bcd_1;
    logic [3:0] bcd_10;
    logic [6:0] seg_1;
    logic [6:0] seg_10;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    int m_count   = 0;
    int m_mode    = M_IDLE;
    int m_elapsed = 0;
    bit m_tq      = 1'b1;
    bit m_done    = 1'b0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    two_digit_countdown #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .preset_1  (preset_1),
        .preset_10 (preset_10),
        .toggle    (toggle),
        .bcd_1     (bcd_1),
        .bcd_10    (bcd_10),
        .seg_1     (seg_1),
        .seg_10    (seg_10),
        .done      (done)
    );

    function automatic logic [7:0] bcd8(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: count as an integer, elapsed cycles since the last start/step
    task automatic model_edge(input bit rs, input bit ld, input int p1, input int p10, input bit tg);
        bit rise;
        if (rs) begin
            m_count = 0; m_mode = M_IDLE; m_elapsed = 0; m_tq = 1'b1; m_done = 1'b0;
        end else begin
            rise = tg && !m_tq;
            m_tq = tg;
            if (ld) begin
                m_count   = 10 * ((p10 > 9) ? 9 : p10) + ((p1 > 9) ? 9 : p1);
                m_mode    = M_IDLE;
                m_elapsed = 0;
            end else if (m_mode == M_IDLE) begin
                if (rise && m_count > 0) begin m_mode = M_RUN; m_elapsed = 0; end
            end else if (m_mode == M_RUN) begin
                if (rise) begin
                    m_mode = M_PAUSE;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == TD) begin
                        m_elapsed = 0;
                        m_count--;
                        if (m_count == 0) m_mode = M_DONE;
                    end
                end
            end else if (m_mode == M_PAUSE) begin
                if (rise) begin m_mode = M_RUN; m_elapsed = 0; end
            end
            m_done = (m_mode == M_DONE);
        end
    endtask

    task automatic step(input bit rs, input bit ld, input int p1, input int p10, input bit tg);
        rst       = rs;
        load      = ld;
        preset_1  = p1[3:0];
        preset_10 = p10[3:0];
        toggle    = tg;
        @(posedge clk);
        model_edge(rs, ld, p1, p10, tg);
        #1;
        chk("model_bcd",    {bcd_10, bcd_1}, bcd8(m_count));
        chk("model_seg_1",  seg_1,  seg_tab[m_count % 10]);
        chk("model_seg_10", seg_10, seg_tab[m_count / 10]);
        chk("model_done",   done,   m_done);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic press();
        step(1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic do_load(input int p10, input int p1);
        step(1'b0, 1'b1, p1, p10, 1'b0);
    endtask

    initial begin
        bit tg_r;
        // Reset
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        chk("rst_bcd", {bcd_10, bcd_1}, 16'h00);
        chk("rst_seg_1", seg_1, 16'h3F);
        chk("rst_seg_10", seg_10, 16'h3F);
        chk("rst_done", done, 16'h0);

        // 1: 23 counts down at TD-cycle intervals
        do_load(2, 3);
        chk("t1_load", {bcd_10, bcd_1}, 16'h23);
        chk("t1_seg_10", seg_10, 16'h5B);
        chk("t1_seg_1", seg_1, 16'h4F);
        press();
        for (int k = 1; k <= 4; k++) begin
            idle(TD - 1);
            chk("t1_hold", {bcd_10, bcd_1}, bcd8(24 - k));
            idle(1);
            chk("t1_dec", {bcd_10, bcd_1}, bcd8(23 - k));
        end

        // 2: 01 reaches 00, done holds, further rise ignored
        do_load(0, 1);
        press();
        idle(TD - 1);
        chk("t2_pre", {bcd_10, bcd_1}, 16'h01);
        chk("t2_pre_done", done, 16'h0);
        idle(1);
        chk("t2_zero", {bcd_10, bcd_1}, 16'h00);
        chk("t2_done", done, 16'h1);
        press();
        idle(TD * 2);
        chk("t2_hold", {bcd_10, bcd_1}, 16'h00);
        chk("t2_done_hold", done, 16'h1);

        // 3: pause freezes count and prescaler; resume restarts a full period
        do_load(5, 0);
        chk("t3_load_clr_done", done, 16'h0);
        press();
        idle(5);
        chk("t3_49", {bcd_10, bcd_1}, 16'h49);
        press();
        idle(20);
        chk("t3_paused", {bcd_10, bcd_1}, 16'h49);
        press();
        idle(TD - 1);
        chk("t3_resume_hold", {bcd_10, bcd_1}, 16'h49);
        idle(1);
        chk("t3_48", {bcd_10, bcd_1}, 16'h48);

        // 4: clamped preset, load beats same-cycle rise
        step(1'b0, 1'b1, 12, 15, 1'b0);
        chk("t4_clamp", {bcd_10, bcd_1}, 16'h99);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b1, 12, 15, 1'b1);
        idle(TD * 2);
        chk("t4_no_start", {bcd_10, bcd_1}, 16'h99);

        // 5: button held through reset does not start
        step(1'b1, 1'b0, 0, 0, 1'b1);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        step(1'b0, 1'b1, 5, 4, 1'b1);
        repeat (TD * 2) step(1'b0, 1'b0, 0, 0, 1'b1);
        chk("t5_held", {bcd_10, bcd_1}, 16'h45);
        idle(1);
        press();
        idle(TD - 1);
        chk("t5_start_hold", {bcd_10, bcd_1}, 16'h45);
        idle(1);
        chk("t5_44", {bcd_10, bcd_1}, 16'h44);

        // 6: reset mid-run
        do_load(4, 0);
        press();
        idle(3 * TD);
        chk("t6_37", {bcd_10, bcd_1}, 16'h37);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        chk("t6_rst_bcd", {bcd_10, bcd_1}, 16'h00);
        chk("t6_rst_done", done, 16'h0);
        chk("t6_rst_seg_1", seg_1, 16'h3F);
        chk("t6_rst_seg_10", seg_10, 16'h3F);
        idle(TD * 2);
        chk("t6_idle", {bcd_10, bcd_1}, 16'h00);

        // Randomized phase against the model
        tg_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            int p1, p10;
            bit rs, ld;
            rs  = ($urandom_range(0, 79) == 0);
            ld  = ($urandom_range(0, 23) == 0);
            p1  = $urandom_range(0, 15);
            p10 = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 15);
            if ($urandom_range(0, 5) == 0) tg_r = ~tg_r;
            step(rs, ld, p1, p10, tg_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
